// File: rtl/btn_event_arbiter.sv
// Push-button front end: per-button sync + debounce + press detect, pending queue,
// and a round-robin valid/ready event port. Optional auto-repeat under `BTN_REPEAT_EN`.
`timescale 1ns/1ps

module btn_event_arbiter #(
    parameter int unsigned N             = 5,
    parameter int unsigned IDX_W         = 3,
    parameter int unsigned DB_CYCLES     = 1000000,
    parameter int unsigned REPEAT_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [N-1:0]     btn,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_idx,
    output logic [N-1:0]     btn_level,
    output logic [N-1:0]     pending,
    output logic             overflow
);

    localparam int unsigned    CNT_W   = $clog2(DB_CYCLES) + 1;
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);
    localparam logic [IDX_W:0]   SUM_N    = (IDX_W + 1)'(N);

`ifdef BTN_REPEAT_EN
    localparam int unsigned      REP_W    = $clog2(REPEAT_CYCLES) + 1;
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
`else
    logic w_unused_rep;
    assign w_unused_rep = ^32'(REPEAT_CYCLES);
`endif

    typedef enum logic [1:0] {
        LO      = 2'd0,
        WAIT_HI = 2'd1,
        HI      = 2'd2,
        WAIT_LO = 2'd3
    } db_state_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    logic [N-1:0] w_press;

    for (genvar gi = 0; gi < N; gi++) begin : g_btn
        logic             r_sync1;
        logic             r_sync2;
        db_state_t        r_state;
        logic [CNT_W-1:0] r_cnt;
        logic             r_level;
        logic             r_press;
`ifdef BTN_REPEAT_EN
        logic [REP_W-1:0] r_rep;
`endif

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= btn[gi];
                r_sync2 <= r_sync1;
            end
        end

        // Debounce FSM; the counter saturates rather than wrapping.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_state <= LO;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_press <= 1'b0;
`ifdef BTN_REPEAT_EN
                r_rep   <= '0;
`endif
            end else begin
                r_press <= 1'b0;
                case (r_state)
                    LO: begin
                        r_cnt <= '0;
                        if (r_sync2) r_state <= WAIT_HI;
                    end
                    WAIT_HI: begin
                        if (!r_sync2) begin
                            r_state <= LO;
                            r_cnt   <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_state <= HI;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_press <= 1'b1;
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    HI: begin
                        r_cnt <= '0;
                        if (!r_sync2) r_state <= WAIT_LO;
                    end
                    WAIT_LO: begin
                        if (r_sync2) begin
                            r_state <= HI;
                            r_cnt   <= '0;
                        end else if (r_cnt == DB_LAST) begin
                            r_state <= LO;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                        end else if (r_cnt != '1) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= LO;
                        r_cnt   <= '0;
                    end
                endcase
`ifdef BTN_REPEAT_EN
                // Auto-repeat only while the debounced level is steadily high.
                if (r_state == HI) begin
                    if (r_rep == REP_LAST) begin
                        r_rep   <= '0;
                        r_press <= 1'b1;
                    end else begin
                        r_rep <= r_rep + REP_W'(1);
                    end
                end else begin
                    r_rep <= '0;
                end
`endif
            end
        end

        assign w_press[gi]   = r_press;
        assign btn_level[gi] = r_level;
    end

    arb_state_t       r_state;
    logic             r_evt_valid;
    logic [IDX_W-1:0] r_evt_idx;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [N-1:0]     r_pending;
    logic             r_overflow;

    logic             w_accept;
    logic             w_load;
    logic [IDX_W-1:0] w_next_ptr;
    logic [IDX_W-1:0] w_base;
    logic [2*N-1:0]   w_dbl_shift;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_sel;
    logic [N-1:0]     w_clr;

    assign w_accept   = r_evt_valid & evt_ready;
    assign w_next_ptr = (r_evt_idx == IDX_LAST) ? '0 : r_evt_idx + IDX_W'(1);
    // On accept the scan already starts after the winner, so back-to-back loads stay fair.
    assign w_base      = (r_state == OFFER) ? w_next_ptr : r_rr_ptr;
    assign w_dbl_shift = {r_pending, r_pending} >> w_base;
    assign w_rot       = w_dbl_shift[N-1:0];

    always_comb begin
        w_off = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_off = IDX_W'(k);
        end
    end

    assign w_sum  = {1'b0, w_base} + {1'b0, w_off};
    assign w_sel  = (w_sum >= SUM_N) ? IDX_W'(w_sum - SUM_N) : IDX_W'(w_sum);
    assign w_load = (|r_pending) & ((r_state == IDLE) | w_accept);
    assign w_clr  = w_load ? (N'(1) << w_sel) : '0;

    // Pending queue, sticky overflow and the single-register event offer.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= IDLE;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
            r_rr_ptr    <= '0;
            r_pending   <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_press;
            if (ovf_clr) r_overflow <= 1'b0;
            if (|(w_press & r_pending)) r_overflow <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_load) begin
                        r_state     <= OFFER;
                        r_evt_valid <= 1'b1;
                        r_evt_idx   <= w_sel;
                    end
                end
                OFFER: begin
                    if (w_accept) begin
                        r_rr_ptr <= w_next_ptr;
                        if (w_load) begin
                            r_evt_idx <= w_sel;
                        end else begin
                            r_state     <= IDLE;
                            r_evt_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid = r_evt_valid;
    assign evt_idx   = r_evt_idx;
    assign pending   = r_pending;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter (N=5, DB_CYCLES=4, default build without auto-repeat).
`timescale 1ns/1ps

module tb_btn_event_arbiter;

    localparam int unsigned N     = 5;
    localparam int unsigned IDX_W = 3;

    logic             clk = 1'b0;
    logic             rstn;
    logic [N-1:0]     btn;
    logic             evt_ready;
    logic             ovf_clr;
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic [N-1:0]     btn_level;
    logic [N-1:0]     pending;
    logic             overflow;

    int checks   = 0;
    int errors   = 0;
    int n_events = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N(N), .IDX_W(IDX_W), .DB_CYCLES(4), .REPEAT_CYCLES(10)
    ) dut (
        .clk(clk), .rstn(rstn), .btn(btn), .evt_ready(evt_ready), .ovf_clr(ovf_clr),
        .evt_valid(evt_valid), .evt_idx(evt_idx), .btn_level(btn_level),
        .pending(pending), .overflow(overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_release(input int i);
        btn[i] = 1'b1;
        cyc(10);
        btn[i] = 1'b0;
        cyc(12);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"},   int'(evt_valid), 0);
        check({tag, "_idx"},     int'(evt_idx),   0);
        check({tag, "_level"},   int'(btn_level), 0);
        check({tag, "_pending"}, int'(pending),   0);
        check({tag, "_ovf"},     int'(overflow),  0);
    endtask

    // Monitor: every accepted handshake is matched against the scoreboard queue.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            #3;
            if (rstn && evt_valid && evt_ready) begin
                n_events++;
                if (exp_q.size() == 0) begin
                    check("unexpected_event_idx", int'(evt_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("event_idx", int'(evt_idx), e);
                end
            end
        end
    end

    initial begin
        rstn      = 1'b1;
        btn       = '0;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #2 rstn = 1'b0;
        #1 check_all_zero("reset");
        cyc(3);
        rstn = 1'b1;
        cyc(2);

        // Clean press on button 2.
        evt_ready = 1'b1;
        exp_q.push_back(2);
        btn[2] = 1'b1;
        cyc(6);
        check("clean_level_before", int'(btn_level[2]), 0);
        cyc(1);
        check("clean_level_rise", int'(btn_level[2]), 1);
        cyc(2);
        check("clean_valid", int'(evt_valid), 1);
        check("clean_idx", int'(evt_idx), 2);
        cyc(1);
        check("clean_valid_drop", int'(evt_valid), 0);
        cyc(10);
        btn[2] = 1'b0;
        cyc(12);
        check("clean_level_fall", int'(btn_level[2]), 0);

        // Bouncing button 0, then held.
        exp_q.push_back(0);
        for (int k = 0; k < 12; k++) begin
            btn[0] = ((k / 2) % 2) == 0;
            cyc(1);
        end
        check("bounce_level", int'(btn_level[0]), 0);
        check("bounce_pending", int'(pending), 0);
        btn[0] = 1'b1;
        cyc(20);
        check("bounce_level_held", int'(btn_level[0]), 1);
        btn[0] = 1'b0;
        cyc(15);

        // Contention between buttons 1 and 3 with the consumer stalled.
        evt_ready = 1'b0;
        exp_q.push_back(1);
        exp_q.push_back(3);
        btn[1] = 1'b1;
        btn[3] = 1'b1;
        cyc(12);
        check("cont_valid", int'(evt_valid), 1);
        check("cont_idx_held", int'(evt_idx), 1);
        check("cont_pending", int'(pending), 8);
        evt_ready = 1'b1;
        cyc(1);
        check("cont_b2b_valid", int'(evt_valid), 1);
        check("cont_b2b_idx", int'(evt_idx), 3);
        check("cont_b2b_pending", int'(pending), 0);
        cyc(1);
        check("cont_valid_drop", int'(evt_valid), 0);
        btn[1] = 1'b0;
        btn[3] = 1'b0;
        cyc(12);

        // Round-robin: pointer sits at 4 after accepting index 3.
        exp_q.push_back(4);
        exp_q.push_back(0);
        btn[0] = 1'b1;
        btn[4] = 1'b1;
        cyc(9);
        check("rr_first_valid", int'(evt_valid), 1);
        check("rr_first_idx", int'(evt_idx), 4);
        cyc(1);
        check("rr_second_valid", int'(evt_valid), 1);
        check("rr_second_idx", int'(evt_idx), 0);
        cyc(1);
        check("rr_valid_drop", int'(evt_valid), 0);
        cyc(3);
        btn[0] = 1'b0;
        btn[4] = 1'b0;
        cyc(12);

        // Overflow: three presses of button 1 while stalled.
        evt_ready = 1'b0;
        exp_q.push_back(1);
        press_release(1);
        check("ovf_p1_valid", int'(evt_valid), 1);
        check("ovf_p1_idx", int'(evt_idx), 1);
        check("ovf_p1_pending", int'(pending), 0);
        exp_q.push_back(1);
        press_release(1);
        check("ovf_p2_pending", int'(pending), 2);
        check("ovf_p2_ovf", int'(overflow), 0);
        press_release(1);
        check("ovf_p3_ovf", int'(overflow), 1);
        check("ovf_p3_pending", int'(pending), 2);
        check("ovf_p3_idx", int'(evt_idx), 1);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", int'(overflow), 0);
        evt_ready = 1'b1;
        cyc(1);
        check("ovf_second_valid", int'(evt_valid), 1);
        check("ovf_second_idx", int'(evt_idx), 1);
        check("ovf_second_pending", int'(pending), 0);
        cyc(1);
        check("ovf_valid_drop", int'(evt_valid), 0);

        // Reset mid-operation with button 4 held through it.
        evt_ready = 1'b0;
        press_release(1);
        btn[1] = 1'b1;
        btn[4] = 1'b1;
        cyc(10);
        btn[1] = 1'b0;
        cyc(12);
        check("rst_pre_valid", int'(evt_valid), 1);
        check("rst_pre_idx", int'(evt_idx), 1);
        check("rst_pre_pending", int'(pending), 18);
        #2 rstn = 1'b0;
        #1 check_all_zero("midrst");
        cyc(3);
        rstn      = 1'b1;
        evt_ready = 1'b1;
        exp_q.push_back(4);
        cyc(6);
        check("rst_level_before", int'(btn_level[4]), 0);
        cyc(1);
        check("rst_level_rise", int'(btn_level[4]), 1);
        cyc(2);
        check("rst_evt_valid", int'(evt_valid), 1);
        check("rst_evt_idx", int'(evt_idx), 4);
        cyc(1);
        check("rst_valid_drop", int'(evt_valid), 0);
        cyc(5);
        btn[4] = 1'b0;
        cyc(15);

        check("queue_drained", exp_q.size(), 0);
        check("event_count", n_events, 9);
        check("final_overflow", int'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
